hamming_secded_decoder: RTL

//  Downstream companion of the 11-bit Hamming SECDED encoder. It accepts a 16-bit codeword and checks it.
//  It corrects any single-bit error, detects double-bit errors, and delivers the 11-bit data word with status flags.
//  The block is a 2-stage valid/ready pipeline with saturating error-statistics counters.

---
 rtl/hamming_pkg.sv | 31 +++
 rtl/hamming_syndrome.sv | 18 +
 rtl/hamming_secded_decoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the 11-bit Hamming SECDED codec: code geometry,
// parity positions, data extraction and the error classification enum.
package hamming_pkg;

  localparam int CODE_W = 16;
  localparam int DATA_W = 11;
  localparam int PARITY_POS [4] = '{1, 2, 4, 8};

  typedef enum logic [1:0] {NONE, CORR, UNCORR} err_kind_t;

  function automatic logic is_parity_pos(input int pos);
    logic hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (PARITY_POS[i] == pos) hit = 1'b1;
    return hit;
  endfunction

  // Data bit k is the k-th non-parity position among 1..15; position 16 is overall parity.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W:1] code);
    logic [DATA_W-1:0] data = '0;
    int k = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (!is_parity_pos(pos)) begin
        data[k] = code[pos];
        k++;
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a 16-bit SECDED codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W:1] code,
  output logic [3:0]      s,
  output logic            p
);

  always_comb begin
    s = '0;
    for (int pos = 1; pos < CODE_W; pos++)
      for (int b = 0; b < 4; b++)
        if (pos[b]) s[b] = s[b] ^ code[pos];
    p = ^code;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage valid/ready SECDED decoder: syndrome in stage 1, correction and
// classification in stage 2, plus saturating corrected/uncorrectable counters.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W:1]   code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [4:0]        err_pos,
  input  logic              clr_counts,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [3:0]        syn_c;
  logic              par_c;
  logic              vld_p1;
  logic [CODE_W:1]   code_p1;
  logic [3:0]        syn_p1;
  logic              par_p1;
  logic              advance_p2;
  err_kind_t         kind_p1;
  logic [CODE_W:1]   fixed_p1;
  logic [4:0]        pos_p1;

  hamming_syndrome u_syndrome (
    .code (code_in),
    .s    (syn_c),
    .p    (par_c)
  );

  assign advance_p2 = !out_valid || out_ready;
  assign in_ready   = !vld_p1 || advance_p2;

  // Stage 1: capture codeword with its syndrome and overall parity
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      code_p1 <= code_in;
      syn_p1  <= syn_c;
      par_p1  <= par_c;
    end
  end

  always_comb begin
    kind_p1  = NONE;
    fixed_p1 = code_p1;
    pos_p1   = '0;
    if (par_p1) begin
      kind_p1 = CORR;
      pos_p1  = (syn_p1 == '0) ? 5'd16 : {1'b0, syn_p1};
      for (int pos = 1; pos < CODE_W; pos++)
        if (syn_p1 == pos[3:0]) fixed_p1[pos] = ~code_p1[pos];
    end else if (syn_p1 != '0) begin
      kind_p1 = UNCORR;
    end
  end

  // Stage 2: corrected data and status, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      err_pos    <= '0;
    end else if (advance_p2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        data_out   <= extract_data(fixed_p1);
        err_corr   <= (kind_p1 == CORR);
        err_uncorr <= (kind_p1 == UNCORR);
        err_pos    <= pos_p1;
      end
    end
  end

  // Clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clr_counts) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (out_valid && out_ready) begin
      if (err_corr)   corr_count   <= sat_inc(corr_count);
      if (err_uncorr) uncorr_count <= sat_inc(uncorr_count);
    end
  end

endmodule
